// File: rtl/reservation_station_age_issue_if.sv
// reservation_station_age_issue_if: dispatch, CDB, flush and issue-port bundle for the reservation station
interface reservation_station_age_issue_if #(
  parameter int SS = 2,
  parameter int DEPTH = 8,
  parameter int ISSUE = 2,
  parameter int CDB_W = 2,
  parameter int TAG_W = 5,
  parameter int PAYLOAD_W = 64,
  parameter int CLASS_W = 2
);
  localparam int FC_W = $clog2(DEPTH + 1);
  logic [SS-1:0] disp_valid;
  logic [SS-1:0][CLASS_W-1:0] disp_class;
  logic [SS-1:0][TAG_W-1:0] disp_src1_tag, disp_src2_tag, disp_dst_tag;
  logic [SS-1:0] disp_src1_rdy, disp_src2_rdy;
  logic [SS-1:0][PAYLOAD_W-1:0] disp_payload;
  logic disp_ready;
  logic [CDB_W-1:0] cdb_valid;
  logic [CDB_W-1:0][TAG_W-1:0] cdb_tag;
  logic flush;
  logic [ISSUE-1:0] iss_valid, iss_ready;
  logic [ISSUE-1:0][CLASS_W-1:0] iss_class;
  logic [ISSUE-1:0][TAG_W-1:0] iss_dst_tag, iss_src1_tag, iss_src2_tag;
  logic [ISSUE-1:0][PAYLOAD_W-1:0] iss_payload;
  logic [FC_W-1:0] free_count;
  modport master (
    output disp_valid, disp_class, disp_src1_tag, disp_src2_tag, disp_src1_rdy, disp_src2_rdy,
           disp_dst_tag, disp_payload, cdb_valid, cdb_tag, flush, iss_ready,
    input  disp_ready, iss_valid, iss_class, iss_dst_tag, iss_src1_tag, iss_src2_tag, iss_payload, free_count
  );
  modport slave (
    input  disp_valid, disp_class, disp_src1_tag, disp_src2_tag, disp_src1_rdy, disp_src2_rdy,
           disp_dst_tag, disp_payload, cdb_valid, cdb_tag, flush, iss_ready,
    output disp_ready, iss_valid, iss_class, iss_dst_tag, iss_src1_tag, iss_src2_tag, iss_payload, free_count
  );
endinterface

// File: rtl/reservation_station_age_issue.sv
// reservation_station_age_issue: oldest-first multi-port reservation station; define RS_WAKEUP_BYPASS_EN for same-cycle CDB-to-issue bypass
module reservation_station_age_issue #(
  parameter int SS = 2,
  parameter int DEPTH = 8,
  parameter int ISSUE = 2,
  parameter int CDB_W = 2,
  parameter int TAG_W = 5,
  parameter int PAYLOAD_W = 64,
  parameter int CLASS_W = 2,
  parameter logic [ISSUE*(2**CLASS_W)-1:0] ISSUE_CLASS_MASK = 8'hA5
) (
  input logic clk,
  input logic rst_n,
  reservation_station_age_issue_if.slave rs
);
  localparam int NCLS = 2**CLASS_W;
  localparam int FC_W = $clog2(DEPTH + 1);
  localparam logic [ISSUE-1:0][NCLS-1:0] MASK = ISSUE_CLASS_MASK;
  logic [DEPTH-1:0] valid, r1, r2, hit1, hit2, elig, issued;
  logic [DEPTH-1:0][CLASS_W-1:0] cls;
  logic [DEPTH-1:0][TAG_W-1:0] s1, s2, dst;
  logic [DEPTH-1:0][PAYLOAD_W-1:0] pay;
  logic [DEPTH-1:0][DEPTH-1:0] older;
  logic [SS-1:0] dhit1, dhit2, alloc_en;
  logic [SS-1:0][DEPTH-1:0] alloc_oh, younger;
  logic [FC_W-1:0] cnt;
  // CDB tag match against every waiting source and every dispatching source
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    dhit1 = '0;
    dhit2 = '0;
    for (int k = 0; k < CDB_W; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        hit1[i] = hit1[i] | (rs.cdb_valid[k] && rs.cdb_tag[k] == s1[i]);
        hit2[i] = hit2[i] | (rs.cdb_valid[k] && rs.cdb_tag[k] == s2[i]);
      end
      for (int l = 0; l < SS; l++) begin
        dhit1[l] = dhit1[l] | (rs.cdb_valid[k] && rs.cdb_tag[k] == rs.disp_src1_tag[l]);
        dhit2[l] = dhit2[l] | (rs.cdb_valid[k] && rs.cdb_tag[k] == rs.disp_src2_tag[l]);
      end
    end
  end
`ifdef RS_WAKEUP_BYPASS_EN
  assign elig = valid & (r1 | hit1) & (r2 | hit2);
`else
  assign elig = valid & r1 & r2;
`endif
  // occupancy from registered valid bits only, so same-cycle issues never count as free
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + FC_W'(valid[i]);
  end
  assign rs.free_count = FC_W'(DEPTH) - cnt;
  assign rs.disp_ready = rs.free_count >= FC_W'(SS);
  // lanes take the lowest free entries in lane order; younger[l] marks entries taken by later lanes
  always_comb begin
    logic [DEPTH-1:0] f;
    logic found;
    f = ~valid;
    for (int l = 0; l < SS; l++) begin
      alloc_oh[l] = '0;
      found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!found && f[i]) begin
          alloc_oh[l][i] = 1'b1;
          found = 1'b1;
        end
      end
      alloc_en[l] = rs.disp_valid[l] && rs.disp_ready && !rs.flush && found;
      f = alloc_en[l] ? f & ~alloc_oh[l] : f;
    end
    for (int l = 0; l < SS; l++) begin
      younger[l] = '0;
      for (int m = l + 1; m < SS; m++) younger[l] = younger[l] | (alloc_en[m] ? alloc_oh[m] : '0);
    end
  end
  // per-port oldest-first pick over accepted classes, excluding entries claimed by lower ports
  always_comb begin
    logic [DEPTH-1:0] taken, cand, pk;
    taken = '0;
    issued = '0;
    for (int p = 0; p < ISSUE; p++) begin
      for (int i = 0; i < DEPTH; i++) cand[i] = elig[i] && MASK[p][cls[i]] && !taken[i];
      for (int i = 0; i < DEPTH; i++) begin
        pk[i] = cand[i];
        for (int j = 0; j < DEPTH; j++) if (j != i && cand[j] && !older[i][j]) pk[i] = 1'b0;
      end
      taken = taken | pk;
      rs.iss_valid[p] = |pk && !rs.flush;
      rs.iss_class[p] = '0;
      rs.iss_dst_tag[p] = '0;
      rs.iss_src1_tag[p] = '0;
      rs.iss_src2_tag[p] = '0;
      rs.iss_payload[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (pk[i]) begin
          rs.iss_class[p] = cls[i];
          rs.iss_dst_tag[p] = dst[i];
          rs.iss_src1_tag[p] = s1[i];
          rs.iss_src2_tag[p] = s2[i];
          rs.iss_payload[p] = pay[i];
        end
      end
      if (rs.iss_valid[p] && rs.iss_ready[p]) issued = issued | pk;
    end
  end
  // entry valid/ready bits and age matrix; older[i][j] means entry i is older than entry j
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      r1 <= '0;
      r2 <= '0;
      older <= '0;
    end else if (rs.flush) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issued[i]) valid[i] <= 1'b0;
        r1[i] <= r1[i] | hit1[i];
        r2[i] <= r2[i] | hit2[i];
      end
      for (int l = 0; l < SS; l++) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (alloc_en[l] && alloc_oh[l][i]) begin
            valid[i] <= 1'b1;
            r1[i] <= rs.disp_src1_rdy[l] | dhit1[l];
            r2[i] <= rs.disp_src2_rdy[l] | dhit2[l];
            for (int j = 0; j < DEPTH; j++) begin
              older[i][j] <= younger[l][j];
              older[j][i] <= !(younger[l][j] || alloc_oh[l][j]);
            end
          end
        end
      end
    end
  end
  // entry payload fields, written only on allocation
  always_ff @(posedge clk) begin
    for (int l = 0; l < SS; l++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_en[l] && alloc_oh[l][i]) begin
          cls[i] <= rs.disp_class[l];
          s1[i] <= rs.disp_src1_tag[l];
          s2[i] <= rs.disp_src2_tag[l];
          dst[i] <= rs.disp_dst_tag[l];
          pay[i] <= rs.disp_payload[l];
        end
      end
    end
  end
endmodule

// File: tb/tb_reservation_station_age_issue.sv
// tb_reservation_station_age_issue: scoreboard bench for the age-ordered reservation station
module tb_reservation_station_age_issue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  reservation_station_age_issue_if bus();
  reservation_station_age_issue dut (.clk(clk), .rst_n(rst_n), .rs(bus));
`ifdef RS_WAKEUP_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  int passed = 0;
  int total = 0;
  logic [63:0] exp_q[2][$];
  logic [63:0] e;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task idle;
    bus.disp_valid = '0;
    bus.disp_class = '0;
    bus.disp_src1_tag = '0;
    bus.disp_src2_tag = '0;
    bus.disp_src1_rdy = '0;
    bus.disp_src2_rdy = '0;
    bus.disp_dst_tag = '0;
    bus.disp_payload = '0;
    bus.cdb_valid = '0;
    bus.cdb_tag = '0;
    bus.flush = 1'b0;
  endtask

  task lane(input int l, input logic [1:0] c, input logic [4:0] t1, input logic q1,
            input logic [4:0] t2, input logic q2, input logic [63:0] pl);
    bus.disp_valid[l] = 1'b1;
    bus.disp_class[l] = c;
    bus.disp_src1_tag[l] = t1;
    bus.disp_src1_rdy[l] = q1;
    bus.disp_src2_tag[l] = t2;
    bus.disp_src2_rdy[l] = q2;
    bus.disp_dst_tag[l] = pl[4:0];
    bus.disp_payload[l] = pl;
  endtask

  task test_reset;
    idle;
    bus.iss_ready = '0;
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (bus.iss_valid !== 2'b00) $display("FAIL reset_iss_valid: got %b required 00", bus.iss_valid); else passed++;
    total++; if (bus.free_count !== 4'd8) $display("FAIL reset_free_count: got %0d required 8", bus.free_count); else passed++;
    total++; if (bus.disp_ready !== 1'b1) $display("FAIL reset_disp_ready: got %b required 1", bus.disp_ready); else passed++;
    #2 rst_n = 1'b1;
    tick;
  endtask

  task test_dual_issue;
    idle;
    bus.iss_ready = 2'b11;
    lane(0, 2'd0, 5'd1, 1'b1, 5'd2, 1'b1, 64'h100);
    lane(1, 2'd1, 5'd3, 1'b1, 5'd4, 1'b1, 64'h101);
    exp_q[0].push_back(64'h100);
    exp_q[1].push_back(64'h101);
    @(negedge clk);
    total++; if (bus.iss_valid !== 2'b00) $display("FAIL dual_no_same_cycle: got %b required 00", bus.iss_valid); else passed++;
    tick;
    idle;
    @(negedge clk);
    total++; if (bus.iss_valid !== 2'b11) $display("FAIL dual_iss_valid: got %b required 11", bus.iss_valid); else passed++;
    total++; if (bus.free_count !== 4'd6) $display("FAIL dual_free_count: got %0d required 6", bus.free_count); else passed++;
    for (int p = 0; p < 2; p++) if (bus.iss_valid[p] && bus.iss_ready[p]) begin
      total++;
      if (exp_q[p].size() == 0) $display("FAIL dual_issue_p%0d: got %h required nothing", p, bus.iss_payload[p]);
      else begin e = exp_q[p].pop_front(); if (bus.iss_payload[p] !== e) $display("FAIL dual_issue_p%0d: got %h required %h", p, bus.iss_payload[p], e); else passed++; end
    end
    tick;
    @(negedge clk);
    total++; if (bus.free_count !== 4'd8) $display("FAIL dual_free_after: got %0d required 8", bus.free_count); else passed++;
    total++; if (exp_q[0].size() + exp_q[1].size() != 0) $display("FAIL dual_drained: got %0d pending required 0", exp_q[0].size() + exp_q[1].size()); else passed++;
    tick;
  endtask

  task test_cdb_wakeup;
    logic ev;
    bus.iss_ready = 2'b01;
    for (int c = 0; c < 9; c++) begin
      idle;
      if (c < 3) begin
        lane(0, 2'd0, 5'd5, 1'b0, 5'd6, 1'b1, 64'h200 + 64'(c));
        exp_q[0].push_back(64'h200 + 64'(c));
      end
      if (c == 4) begin
        bus.cdb_valid = 2'b01;
        bus.cdb_tag[0] = 5'd5;
      end
      @(negedge clk);
      ev = (c >= 5 - BYP) && (c <= 7 - BYP);
      total++; if (bus.iss_valid !== {1'b0, ev}) $display("FAIL wake_iss_valid_c%0d: got %b required %b", c, bus.iss_valid, {1'b0, ev}); else passed++;
      for (int p = 0; p < 2; p++) if (bus.iss_valid[p] && bus.iss_ready[p]) begin
        total++;
        if (exp_q[p].size() == 0) $display("FAIL wake_issue_p%0d: got %h required nothing", p, bus.iss_payload[p]);
        else begin e = exp_q[p].pop_front(); if (bus.iss_payload[p] !== e) $display("FAIL wake_issue_p%0d: got %h required %h", p, bus.iss_payload[p], e); else passed++; end
      end
      tick;
    end
    total++; if (exp_q[0].size() != 0) $display("FAIL wake_drained: got %0d pending required 0", exp_q[0].size()); else passed++;
  endtask

  task test_full;
    bus.iss_ready = 2'b00;
    for (int c = 0; c < 4; c++) begin
      idle;
      lane(0, 2'd0, 5'd20, 1'b0, 5'd20, 1'b0, 64'h300 + 64'(2 * c));
      lane(1, 2'd0, 5'd20, 1'b0, 5'd20, 1'b0, 64'h301 + 64'(2 * c));
      exp_q[0].push_back(64'h300 + 64'(2 * c));
      exp_q[0].push_back(64'h301 + 64'(2 * c));
      if (c == 3) begin
        @(negedge clk);
        total++; if (bus.free_count !== 4'd2) $display("FAIL full_free6: got %0d required 2", bus.free_count); else passed++;
        total++; if (bus.disp_ready !== 1'b1) $display("FAIL full_ready6: got %b required 1", bus.disp_ready); else passed++;
      end
      tick;
    end
    idle;
    lane(0, 2'd0, 5'd1, 1'b1, 5'd1, 1'b1, 64'h3F0);
    lane(1, 2'd2, 5'd1, 1'b1, 5'd1, 1'b1, 64'h3F1);
    @(negedge clk);
    total++; if (bus.free_count !== 4'd0) $display("FAIL full_free8: got %0d required 0", bus.free_count); else passed++;
    total++; if (bus.disp_ready !== 1'b0) $display("FAIL full_ready8: got %b required 0", bus.disp_ready); else passed++;
    tick;
    idle;
    @(negedge clk);
    total++; if (bus.free_count !== 4'd0) $display("FAIL full_ignored: got %0d required 0", bus.free_count); else passed++;
    bus.cdb_valid = 2'b01;
    bus.cdb_tag[0] = 5'd20;
    tick;
    idle;
    bus.iss_ready = 2'b01;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) if (bus.iss_valid[p] && bus.iss_ready[p]) begin
        total++;
        if (exp_q[p].size() == 0) $display("FAIL full_issue_p%0d: got %h required nothing", p, bus.iss_payload[p]);
        else begin e = exp_q[p].pop_front(); if (bus.iss_payload[p] !== e) $display("FAIL full_issue_p%0d: got %h required %h", p, bus.iss_payload[p], e); else passed++; end
      end
      tick;
    end
    @(negedge clk);
    total++; if (bus.free_count !== 4'd8) $display("FAIL full_free_after: got %0d required 8", bus.free_count); else passed++;
    total++; if (exp_q[0].size() != 0) $display("FAIL full_drained: got %0d pending required 0", exp_q[0].size()); else passed++;
    tick;
  endtask

  task test_same_cycle_capture;
    idle;
    bus.iss_ready = 2'b01;
    lane(0, 2'd0, 5'd7, 1'b1, 5'd9, 1'b0, 64'h400);
    bus.cdb_valid = 2'b10;
    bus.cdb_tag[1] = 5'd9;
    exp_q[0].push_back(64'h400);
    @(negedge clk);
    total++; if (bus.iss_valid !== 2'b00) $display("FAIL capture_early: got %b required 00", bus.iss_valid); else passed++;
    tick;
    idle;
    @(negedge clk);
    total++; if (bus.iss_valid !== 2'b01) $display("FAIL capture_iss_valid: got %b required 01", bus.iss_valid); else passed++;
    for (int p = 0; p < 2; p++) if (bus.iss_valid[p] && bus.iss_ready[p]) begin
      total++;
      if (exp_q[p].size() == 0) $display("FAIL capture_issue_p%0d: got %h required nothing", p, bus.iss_payload[p]);
      else begin e = exp_q[p].pop_front(); if (bus.iss_payload[p] !== e) $display("FAIL capture_issue_p%0d: got %h required %h", p, bus.iss_payload[p], e); else passed++; end
    end
    tick;
    @(negedge clk);
    total++; if (exp_q[0].size() != 0) $display("FAIL capture_drained: got %0d pending required 0", exp_q[0].size()); else passed++;
    tick;
  endtask

  task test_flush;
    idle;
    bus.iss_ready = 2'b00;
    lane(0, 2'd0, 5'd1, 1'b1, 5'd1, 1'b1, 64'h500);
    lane(1, 2'd1, 5'd1, 1'b1, 5'd1, 1'b1, 64'h501);
    tick;
    idle;
    lane(0, 2'd2, 5'd1, 1'b1, 5'd1, 1'b1, 64'h502);
    lane(1, 2'd3, 5'd1, 1'b1, 5'd1, 1'b1, 64'h503);
    tick;
    idle;
    @(negedge clk);
    total++; if (bus.iss_valid !== 2'b11) $display("FAIL flush_held_valid: got %b required 11", bus.iss_valid); else passed++;
    total++; if (bus.free_count !== 4'd4) $display("FAIL flush_free4: got %0d required 4", bus.free_count); else passed++;
    total++; if (bus.iss_payload[0] !== 64'h500) $display("FAIL flush_oldest_p0: got %h required %h", bus.iss_payload[0], 64'h500); else passed++;
    tick;
    bus.flush = 1'b1;
    bus.iss_ready = 2'b11;
    lane(0, 2'd0, 5'd1, 1'b1, 5'd1, 1'b1, 64'h5F0);
    @(negedge clk);
    total++; if (bus.iss_valid !== 2'b00) $display("FAIL flush_iss_valid: got %b required 00", bus.iss_valid); else passed++;
    tick;
    idle;
    bus.iss_ready = 2'b00;
    @(negedge clk);
    total++; if (bus.free_count !== 4'd8) $display("FAIL flush_free_after: got %0d required 8", bus.free_count); else passed++;
    total++; if (bus.iss_valid !== 2'b00) $display("FAIL flush_empty: got %b required 00", bus.iss_valid); else passed++;
    tick;
  endtask

  task test_async_reset;
    idle;
    bus.iss_ready = 2'b00;
    lane(0, 2'd0, 5'd1, 1'b1, 5'd1, 1'b1, 64'h600);
    lane(1, 2'd1, 5'd1, 1'b1, 5'd1, 1'b1, 64'h601);
    tick;
    idle;
    @(negedge clk);
    total++; if (bus.iss_valid !== 2'b11) $display("FAIL areset_pre_valid: got %b required 11", bus.iss_valid); else passed++;
    bus.iss_ready = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.iss_valid !== 2'b00) $display("FAIL areset_iss_valid: got %b required 00", bus.iss_valid); else passed++;
    total++; if (bus.free_count !== 4'd8) $display("FAIL areset_free_count: got %0d required 8", bus.free_count); else passed++;
    tick;
    #2 rst_n = 1'b1;
    tick;
    @(negedge clk);
    total++; if (bus.free_count !== 4'd8) $display("FAIL areset_free_after: got %0d required 8", bus.free_count); else passed++;
    total++; if (bus.disp_ready !== 1'b1) $display("FAIL areset_ready_after: got %b required 1", bus.disp_ready); else passed++;
    total++; if (bus.iss_valid !== 2'b00) $display("FAIL areset_valid_after: got %b required 00", bus.iss_valid); else passed++;
    tick;
  endtask

  task test_back_to_back;
    logic [1:0] cl;
    logic [63:0] pl;
    pl = 64'h700;
    for (int c = 0; c < 45; c++) begin
      idle;
      bus.iss_ready = c < 30 ? 2'($urandom_range(0, 3)) : 2'b11;
      if (c < 30 && bus.disp_ready) begin
        for (int l = 0; l < 2; l++) if ($urandom_range(0, 3) != 0) begin
          cl = 2'($urandom_range(0, 3));
          lane(l, cl, 5'd1, 1'b1, 5'd2, 1'b1, pl);
          exp_q[cl[0]].push_back(pl);
          pl = pl + 64'd1;
        end
      end
      @(negedge clk);
      for (int p = 0; p < 2; p++) if (bus.iss_valid[p] && bus.iss_ready[p]) begin
        total++;
        if (exp_q[p].size() == 0) $display("FAIL b2b_issue_p%0d: got %h required nothing", p, bus.iss_payload[p]);
        else begin e = exp_q[p].pop_front(); if (bus.iss_payload[p] !== e) $display("FAIL b2b_issue_p%0d: got %h required %h", p, bus.iss_payload[p], e); else passed++; end
      end
      tick;
    end
    @(negedge clk);
    total++; if (exp_q[0].size() + exp_q[1].size() != 0) $display("FAIL b2b_drained: got %0d pending required 0", exp_q[0].size() + exp_q[1].size()); else passed++;
    total++; if (bus.free_count !== 4'd8) $display("FAIL b2b_free_after: got %0d required 8", bus.free_count); else passed++;
    tick;
  endtask

  initial begin
    test_reset;
    test_dual_issue;
    test_cdb_wakeup;
    test_full;
    test_same_cycle_capture;
    test_flush;
    test_async_reset;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/reservation_station_age_issue.md
Name: reservation_station_age_issue

Overview:
- Parametrised successor to the divider reservation table: a generic out-of-order reservation station with SS dispatch lanes, DEPTH entries, ISSUE issue ports and CDB_W wakeup buses.
- Each issue port serves a configurable set of op classes (e.g. signed/unsigned divider). Selection is oldest-first, and each port has a valid/ready handshake.
- Adds flush, a free-count output and a lane-safe dispatch-ready signal.
- Sits between dispatch/rename and the functional units.

Parameters:
SS, 2, dispatch lanes per cycle (lane 0 older than lane 1)
DEPTH, 8, entries; DEPTH >= SS
ISSUE, 2, issue ports
CDB_W, 2, CDB broadcast buses
TAG_W, 5, physical/ROB tag width
PAYLOAD_W, 64, opaque per-entry payload width
CLASS_W, 2, op-class width
ISSUE_CLASS_MASK, 8'hA5, ISSUE*2^CLASS_W bits; port p accepts class c iff bit p*2^CLASS_W+c is set (default: port0 classes 0,2; port1 classes 1,3)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
disp_valid  in  SS  per-lane instruction valid
disp_class  in  SS x CLASS_W  op class
disp_src1_tag, disp_src2_tag  in  SS x TAG_W  source tags
disp_src1_rdy, disp_src2_rdy  in  SS  source already available
disp_dst_tag  in  SS x TAG_W  destination tag
disp_payload  in  SS x PAYLOAD_W  opaque payload
disp_ready  out  1  station can accept SS lanes this cycle
cdb_valid  in  CDB_W  broadcast valid
cdb_tag  in  CDB_W x TAG_W  broadcast tag
flush  in  1  synchronous squash of all entries
iss_valid  out  ISSUE  port has a selected entry
iss_ready  in  ISSUE  FU accepts
iss_class, iss_dst_tag, iss_src1_tag, iss_src2_tag, iss_payload  out  per port  selected entry fields
free_count  out  $clog2(DEPTH+1)  free entries

Behaviour:
Reset:
- rst_n low clears all entry valid bits immediately (asynchronous).
- Outputs while in reset: iss_valid=0, free_count=DEPTH, disp_ready=1.
- Age state is cleared.

Dispatch:
- disp_ready = (free_count >= SS), computed from registered state only. Entries freed this cycle are not counted.
- When disp_ready=1, each lane with disp_valid=1 is written on the clock edge into the lowest-index free entry, with lanes allocated in order.
- When disp_ready=0, lanes are ignored.
- The written entry is younger than every existing entry; lane 1 is younger than lane 0.

Wakeup:
- A source is ready if its disp_*_rdy=1, or if any cdb_valid[k] carries a matching cdb_tag in the dispatch cycle (same-cycle capture).
- A waiting entry whose source tag matches a valid CDB tag sets that source ready at the edge.
- Multiple CDB hits in one cycle are OR-ed.

Eligibility:
- An entry is eligible when valid, src1 ready and src2 ready.
- Without the optional feature, an entry dispatched or woken at edge N is first eligible in the cycle after edge N.

Selection (combinational from state):
- Port 0 picks the oldest eligible entry whose class it accepts.
- Port p picks the oldest eligible, accepted entry not already picked by ports < p.
- One entry is never presented on two ports.
- iss_valid[p] does not depend on iss_ready.
- Selection may change between cycles if an older entry becomes eligible; it is not sticky.

Issue:
- iss_valid[p] && iss_ready[p] frees that entry at the edge.
- free_count increments on the next cycle.

Flush:
- flush=1 forces iss_valid=0 that cycle; no handshake completes.
- Dispatch that cycle is dropped.
- All entries are invalid after the edge.

Simultaneous events:
- Issue and dispatch in the same cycle are independent.
- CDB wakeup of an entry that issues that cycle is harmless.

Optional Feature:
RS_WAKEUP_BYPASS_EN
- Defined: a valid CDB tag in cycle N makes a waiting entry eligible, and issuable, in cycle N itself, via combinational CDB match into selection. This does not apply to entries dispatched in cycle N.
- Undefined: wakeup is registered; earliest issue is cycle N+1.
- Behaviour is otherwise identical.

Test Plan:
1. Reset, then dispatch lane0 class0 srcs ready, lane1 class1 srcs ready, iss_ready=11 → next cycle iss_valid=11, port0 shows lane0, port1 shows lane1; free_count returns to 8 the cycle after.
2. Dispatch 3 class-0 entries with src1 tag 5 not ready in cycles 0,1,2; cdb tag 5 in cycle 4 → cycle 5 port0 presents the cycle-0 entry; with iss_ready=1, cycles 6 and 7 present the cycle-1 and cycle-2 entries.
3. Fill to 6 entries with non-ready sources → free_count=2, disp_ready=1. Dispatch 2 more → free_count=0, disp_ready=0, and further disp_valid is ignored (free_count stays 0).
4. Dispatch lane0 with src2 tag 9 while cdb tag 9 is valid in the same cycle → entry issues the next cycle with no further CDB.
5. 4 ready entries with iss_ready=0 → iss_valid held, free_count=4. Assert flush → iss_valid=0 that cycle, free_count=8 next cycle.
6. Assert rst_n low mid-issue, asynchronously between clock edges → iss_valid drops immediately; after release, free_count=8 and disp_ready=1.
